// File: rtl/alu_share_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states, requester ID.
package alu_share_pkg;

  localparam int OPW_DEF = 2;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef logic id_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit AND/OR/XOR/ADD unit; carry is only meaningful for ADD.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int N   = 4,
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   result,
  output logic           carry
);

  logic [N:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op_e'(op))
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result = sum[N-1:0];
        carry  = sum[N];
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu_core between two valid/ready requesters; one op in flight,
// IDLE -> EXEC -> RESP with a single-cycle tagged response strobe.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N   = 4,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           rsp_carry,
  output logic           busy
);

  state_e         state;
  id_t            last_grant;
  id_t            id_q;
  logic [OPW-1:0] op_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           grant0;
  logic           grant1;
  logic [N-1:0]   core_result;
  logic           core_carry;

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant == 1'b1);
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign busy       = (state != IDLE);

  alu_core #(.N(N), .OPW(OPW)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .carry  (core_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid && req0_ready) begin
            op_q       <= req0_op;
            a_q        <= req0_a;
            b_q        <= req0_b;
            id_q       <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_valid && req1_ready) begin
            op_q       <= req1_op;
            a_q        <= req1_a;
            b_q        <= req1_b;
            id_q       <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= id_q;
          rsp_result <= core_result;
          rsp_zero   <= (core_result == '0);
          rsp_carry  <= core_carry;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (N=4): single ops, flags, round-robin, operand hold, mid-op reset.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_carry, busy;
  logic [3:0] rsp_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(4), .OPW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    if (r) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Called at a negedge with the DUT idle; ends at the negedge after the response cycle.
  task automatic single(input string tag, input logic r, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic ez, input logic ec);
    drive(r, 1'b1, op, a, b);
    #1;
    chk({tag, ".ready"}, r ? req1_ready : req0_ready, 8'd1);
    chk({tag, ".other"}, r ? req0_ready : req1_ready, 8'd0);
    @(posedge clk); #1;
    drive(r, 1'b0, ~op, ~a, ~b);
    @(negedge clk);
    chk({tag, ".exec_busy"}, busy, 8'd1);
    chk({tag, ".exec_rsp"}, rsp_valid, 8'd0);
    chk({tag, ".exec_rdy"}, {req1_ready, req0_ready}, 8'd0);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, rsp_valid, 8'd1);
    chk({tag, ".rsp_id"}, rsp_id, r);
    chk({tag, ".result"}, rsp_result, er);
    chk({tag, ".zero"}, rsp_zero, ez);
    chk({tag, ".carry"}, rsp_carry, ec);
    chk({tag, ".resp_rdy"}, {req1_ready, req0_ready}, 8'd0);
    @(negedge clk);
    chk({tag, ".after_valid"}, rsp_valid, 8'd0);
    chk({tag, ".after_busy"}, busy, 8'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst.busy", busy, 8'd0);
    chk("rst.rsp_valid", rsp_valid, 8'd0);
    chk("rst.rsp_id", rsp_id, 8'd0);
    chk("rst.rsp_result", rsp_result, 8'd0);
    chk("rst.rsp_zero", rsp_zero, 8'd0);
    chk("rst.rsp_carry", rsp_carry, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    pulse_reset();
    chk("rst.ready", {req1_ready, req0_ready}, 8'd0);

    single("and0",   1'b0, 2'b00, 4'b0101, 4'b1011, 4'b0001, 1'b0, 1'b0);
    single("andz1",  1'b1, 2'b00, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
    single("xorz1",  1'b1, 2'b10, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0);
    single("addwrap",1'b0, 2'b11, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
    single("or1",    1'b1, 2'b01, 4'b1000, 4'b0001, 4'b1001, 1'b0, 1'b0);
    single("add0",   1'b0, 2'b11, 4'b0101, 4'b0010, 4'b0111, 1'b0, 1'b0);
    single("addc1",  1'b1, 2'b11, 4'b1010, 4'b1001, 4'b0011, 1'b0, 1'b1);

    // Operand hold: req0 keeps valid high and changes a/b right after acceptance.
    drive(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0100);
    #1 chk("hold.ready", req0_ready, 8'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111);
    @(negedge clk);
    chk("hold.exec_rdy", {req1_ready, req0_ready}, 8'd0);
    @(negedge clk);
    chk("hold.rsp_valid", rsp_valid, 8'd1);
    chk("hold.result", rsp_result, 8'b0111);
    chk("hold.carry", rsp_carry, 8'd0);
    chk("hold.resp_rdy", {req1_ready, req0_ready}, 8'd0);
    @(negedge clk);
    chk("hold.regrant", req0_ready, 8'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("hold2.rsp_valid", rsp_valid, 8'd1);
    chk("hold2.result", rsp_result, 8'b1110);
    chk("hold2.carry", rsp_carry, 8'd1);
    @(negedge clk);

    // Tie directly after reset: grants alternate starting with requester 0.
    pulse_reset();
    drive(1'b0, 1'b1, 2'b01, 4'b1101, 4'b1011);
    drive(1'b1, 1'b1, 2'b10, 4'b1101, 4'b1011);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d.ready0", k), req0_ready, (k % 2 == 0) ? 8'd1 : 8'd0);
      chk($sformatf("rr%0d.ready1", k), req1_ready, (k % 2 == 1) ? 8'd1 : 8'd0);
      @(negedge clk);
      chk($sformatf("rr%0d.exec_rdy", k), {req1_ready, req0_ready}, 8'd0);
      @(negedge clk);
      chk($sformatf("rr%0d.rsp_valid", k), rsp_valid, 8'd1);
      chk($sformatf("rr%0d.rsp_id", k), rsp_id, (k % 2 == 1) ? 8'd1 : 8'd0);
      chk($sformatf("rr%0d.result", k), rsp_result, (k % 2 == 1) ? 8'b0110 : 8'b1111);
      chk($sformatf("rr%0d.zero", k), rsp_zero, 8'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    chk("rr.idle_busy", busy, 8'd0);

    // Reset while the accepted op is in EXEC: it must vanish without a response.
    drive(1'b1, 1'b1, 2'b01, 4'b0101, 4'b1010);
    #1 chk("mid.ready1", req1_ready, 8'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    chk("mid.exec_busy", busy, 8'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid.busy", busy, 8'd0);
    chk("mid.rsp_valid", rsp_valid, 8'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid.quiet%0d", k), rsp_valid, 8'd0);
    end
    drive(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0100);
    drive(1'b1, 1'b1, 2'b01, 4'b0101, 4'b1010);
    #1;
    chk("mid.tie_ready0", req0_ready, 8'd1);
    chk("mid.tie_ready1", req1_ready, 8'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid.rsp_valid2", rsp_valid, 8'd1);
    chk("mid.rsp_id", rsp_id, 8'd0);
    chk("mid.result", rsp_result, 8'b0111);
    @(negedge clk);
    chk("mid.final_busy", busy, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
